instr_prefetch: RTL and testbench

Instruction prefetch unit sitting directly upstream of the IF stage of the 5-stage MIPS pipeline. It fetches sequential words from instruction memory over a request/acknowledge/response handshake and buffers them with their PCs in a small queue. It presents the head entry to IF. On a branch or jump redirect it discards buffered and in-flight words and restarts fetching at the new PC.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/fetch_fifo.sv | 53 +++++
 rtl/instr_prefetch.sv | 145 ++++++++++++++
 tb/tb_instr_prefetch.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: reset PC, nop encoding, fetch FSM state and queue entry layout.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_REQ,
    FS_WAIT,
    FS_DROP
  } fetch_state_t;

  // drop_pend marks a held request whose response must be discarded once acked
  typedef struct packed {
    fetch_state_t state;
    logic         drop_pend;
  } fetch_ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue of {PC, Instr} entries with push, pop, flush and occupancy count.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  fetch_entry_t           wdata,
  output fetch_entry_t           rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_pop;

  assign do_pop = pop && (count != '0);
  assign rdata  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: entries are only visible once count covers them
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= wdata;
  end

  // Slot reservation upstream must make a push into a full queue impossible
  no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    !(push && !clear && count == CW'(DEPTH)));

endmodule

// File: rtl/instr_prefetch.sv
// Sequential instruction prefetcher feeding IF, with redirect flush and in-flight drop.
// Define PREFETCH_BYPASS_EN to forward a returning word straight to the outputs when the queue is empty.
module instr_prefetch
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  input  logic        MemAck,
  input  logic        MemRValid,
  input  logic [31:0] MemRData,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  input  logic        InstrTake,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] NPC
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_ctrl_t  ctrl_q, ctrl_d;
  logic [31:0]  fpc_q, fpc_d;
  logic [31:0]  redir_pc_q, redir_pc_d;
  logic [31:0]  fpc_prev;
  logic         push, pop, clear;
  logic         has_head;
  logic         bypass;
  logic [CW-1:0] count;
  fetch_entry_t head;

  assign fpc_prev = fpc_q - 32'd4;
  assign has_head = (count != '0);

`ifdef PREFETCH_BYPASS_EN
  assign bypass = (ctrl_q.state == FS_WAIT) && MemRValid && !Redirect && !has_head;
`else
  assign bypass = 1'b0;
`endif

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .wdata ('{pc: fpc_prev, instr: MemRData}),
    .rdata (head),
    .count (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q     <= '{state: FS_IDLE, drop_pend: 1'b0};
      fpc_q      <= RESET_PC;
      redir_pc_q <= RESET_PC;
    end else begin
      ctrl_q     <= ctrl_d;
      fpc_q      <= fpc_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  // Next-state: redirect overrides every push, pop and transition
  always_comb begin
    ctrl_d     = ctrl_q;
    fpc_d      = fpc_q;
    redir_pc_d = redir_pc_q;
    push       = 1'b0;
    pop        = InstrTake && has_head;
    clear      = 1'b0;

    if (Redirect) begin
      clear = 1'b1;
      pop   = 1'b0;
      unique case (ctrl_q.state)
        FS_IDLE: fpc_d = RedirectPC;
        FS_REQ: begin
          if (MemAck) begin
            fpc_d            = RedirectPC;
            ctrl_d.drop_pend = 1'b0;
            ctrl_d.state     = FS_DROP;
          end else begin
            // Address must stay stable until ack; park the target
            ctrl_d.drop_pend = 1'b1;
            redir_pc_d       = RedirectPC;
          end
        end
        FS_WAIT: begin
          fpc_d        = RedirectPC;
          ctrl_d.state = MemRValid ? FS_IDLE : FS_DROP;
        end
        FS_DROP: begin
          fpc_d = RedirectPC;
          if (MemRValid) ctrl_d.state = FS_IDLE;
        end
      endcase
    end else begin
      unique case (ctrl_q.state)
        FS_IDLE: if (count < CW'(DEPTH)) ctrl_d.state = FS_REQ;
        FS_REQ: begin
          if (MemAck) begin
            if (ctrl_q.drop_pend) begin
              fpc_d            = redir_pc_q;
              ctrl_d.drop_pend = 1'b0;
              ctrl_d.state     = FS_DROP;
            end else begin
              fpc_d        = fpc_q + 32'd4;
              ctrl_d.state = FS_WAIT;
            end
          end
        end
        FS_WAIT: begin
          if (MemRValid) begin
            push         = !(bypass && InstrTake);
            ctrl_d.state = ((count + CW'(push) - CW'(pop)) < CW'(DEPTH)) ? FS_REQ : FS_IDLE;
          end
        end
        FS_DROP: if (MemRValid) ctrl_d.state = FS_IDLE;
      endcase
    end
  end

  assign MemReq  = (ctrl_q.state == FS_REQ);
  assign MemAddr = fpc_q;

  always_comb begin
    InstrValid = has_head;
    Instr      = has_head ? head.instr : INSTR_NOP;
    PC         = has_head ? head.pc : 32'h0;
    NPC        = has_head ? head.pc + 32'd4 : 32'h0;
    if (bypass) begin
      InstrValid = 1'b1;
      Instr      = MemRData;
      PC         = fpc_prev;
      NPC        = fpc_q;
    end
  end

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch with a small configurable-latency instruction memory.
module tb_instr_prefetch;

  localparam logic [31:0] KEY = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemAck = 1'b0;
  logic        MemRValid = 1'b0;
  logic [31:0] MemRData = 32'h0;
  logic        Redirect = 1'b0;
  logic [31:0] RedirectPC = 32'h0;
  logic        InstrTake = 1'b0;
  logic        InstrValid;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] NPC;

  int total = 0;
  int bad   = 0;
  int ack_delay = 0;
  int rd_lat    = 1;
  int nreq;

  always #5 clk = ~clk;

  instr_prefetch #(.DEPTH(4), .RESET_PC(32'h0000_3000)) dut (
    .clk        (clk),
    .rst        (rst),
    .MemReq     (MemReq),
    .MemAddr    (MemAddr),
    .MemAck     (MemAck),
    .MemRValid  (MemRValid),
    .MemRData   (MemRData),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .InstrTake  (InstrTake),
    .InstrValid (InstrValid),
    .Instr      (Instr),
    .PC         (PC),
    .NPC        (NPC)
  );

  // Memory: ack after ack_delay cycles of MemReq, data rd_lat cycles after ack, word = addr ^ KEY
  int          wait_cnt = 0;
  logic        a1 = 1'b0, a2 = 1'b0;
  logic [31:0] addr1 = 32'h0, addr2 = 32'h0;
  always @(negedge clk) begin
    if (rst) begin
      MemAck = 1'b0; MemRValid = 1'b0; MemRData = 32'h0;
      a1 = 1'b0; a2 = 1'b0; wait_cnt = 0;
    end else begin
      MemRValid = (rd_lat == 1) ? a1 : a2;
      MemRData  = MemRValid ? (((rd_lat == 1) ? addr1 : addr2) ^ KEY) : 32'h0;
      a2 = a1; addr2 = addr1; a1 = 1'b0;
      if (MemReq && wait_cnt >= ack_delay) begin
        MemAck = 1'b1; a1 = 1'b1; addr1 = MemAddr; wait_cnt = 0;
      end else begin
        MemAck = 1'b0;
        wait_cnt = MemReq ? wait_cnt + 1 : 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int max, input string tag);
    int n = 0;
    while (InstrValid !== 1'b1 && n < max) begin tick(); n++; end
    check(tag, 32'(InstrValid), 32'd1);
  endtask

  task automatic wait_req(input int max, input string tag);
    int n = 0;
    while (MemReq !== 1'b1 && n < max) begin tick(); n++; end
    check(tag, 32'(MemReq), 32'd1);
  endtask

  initial begin
    // Reset values
    tick(); tick();
    check("rst_memreq", 32'(MemReq), 32'd0);
    check("rst_addr",   MemAddr, 32'h0000_3000);
    check("rst_valid",  32'(InstrValid), 32'd0);
    check("rst_instr",  Instr, 32'h0);
    check("rst_pc",     PC, 32'h0);
    check("rst_npc",    NPC, 32'h0);

    // Streaming with 1-cycle ack/data and IF always taking
    rst = 1'b0; InstrTake = 1'b1;
    tick();
    check("s_c1_req",  32'(MemReq), 32'd1);
    check("s_c1_addr", MemAddr, 32'h0000_3000);
    tick();
    check("s_c2_valid", 32'(InstrValid), 32'd0);
    tick();
    check("s_c3_valid", 32'(InstrValid), 32'd1);
    check("s_c3_pc",    PC, 32'h0000_3000);
    check("s_c3_npc",   NPC, 32'h0000_3004);
    check("s_c3_instr", Instr, 32'h0000_3000 ^ KEY);
    tick();
    check("s_c4_valid", 32'(InstrValid), 32'd0);
    tick();
    check("s_c5_pc", PC, 32'h0000_3004);
    tick(); tick();
    check("s_c7_pc", PC, 32'h0000_3008);

    // Asynchronous reset mid-transaction
    #2 rst = 1'b1;
    #1;
    check("arst_memreq", 32'(MemReq), 32'd0);
    check("arst_addr",   MemAddr, 32'h0000_3000);
    check("arst_valid",  32'(InstrValid), 32'd0);

    // Queue fill with no takes: exactly DEPTH requests
    InstrTake = 1'b0;
    tick(); rst = 1'b0;
    nreq = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (MemReq) begin
        check("fill_addr", MemAddr, 32'h0000_3000 + 32'(4 * nreq));
        nreq++;
      end
    end
    check("fill_nreq",   32'(nreq), 32'd4);
    check("fill_idle",   32'(MemReq), 32'd0);
    check("fill_head",   PC, 32'h0000_3000);
    check("fill_nxaddr", MemAddr, 32'h0000_3010);
    InstrTake = 1'b1;
    tick();
    InstrTake = 1'b0;
    check("take_head",  PC, 32'h0000_3004);
    check("take_noreq", 32'(MemReq), 32'd0);
    tick();
    check("take_req",  32'(MemReq), 32'd1);
    check("take_addr", MemAddr, 32'h0000_3010);

    // Redirect during WAIT, stale data a cycle later
    rst = 1'b1; rd_lat = 2;
    tick(); rst = 1'b0;
    tick(); tick(); tick(); tick();
    check("rw_head", PC, 32'h0000_3000);
    check("rw_addr", MemAddr, 32'h0000_3004);
    tick();
    check("rw_wait", 32'(MemReq), 32'd0);
    Redirect = 1'b1; RedirectPC = 32'h0000_4000;
    tick();
    Redirect = 1'b0;
    check("rw_flush", 32'(InstrValid), 32'd0);
    check("rw_fpc",   MemAddr, 32'h0000_4000);
    wait_req(20, "rw_req_to");
    check("rw_newaddr", MemAddr, 32'h0000_4000);
    wait_valid(20, "rw_valid_to");
    check("rw_newpc",  PC, 32'h0000_4000);
    check("rw_newins", Instr, 32'h0000_4000 ^ KEY);

    // Redirect while a request waits 3 cycles for ack
    rst = 1'b1; rd_lat = 1; ack_delay = 3;
    tick(); rst = 1'b0;
    tick();
    check("rq_c1_addr", MemAddr, 32'h0000_3000);
    tick();
    Redirect = 1'b1; RedirectPC = 32'h0000_5000;
    tick();
    Redirect = 1'b0;
    check("rq_c3_req",   32'(MemReq), 32'd1);
    check("rq_c3_addr",  MemAddr, 32'h0000_3000);
    check("rq_c3_valid", 32'(InstrValid), 32'd0);
    tick();
    check("rq_c4_addr", MemAddr, 32'h0000_3000);
    tick();
    check("rq_c5_req",  32'(MemReq), 32'd0);
    check("rq_c5_addr", MemAddr, 32'h0000_5000);
    wait_req(30, "rq_req_to");
    check("rq_newaddr", MemAddr, 32'h0000_5000);
    wait_valid(30, "rq_valid_to");
    check("rq_newpc", PC, 32'h0000_5000);

    // Fetch address wrap at the top of the address space
    ack_delay = 0;
    Redirect = 1'b1; RedirectPC = 32'hFFFF_FFFC;
    tick();
    Redirect = 1'b0;
    check("wr_flush", 32'(InstrValid), 32'd0);
    check("wr_fpc",   MemAddr, 32'hFFFF_FFFC);
    wait_valid(20, "wr_valid_to");
    check("wr_pc",    PC, 32'hFFFF_FFFC);
    check("wr_npc",   NPC, 32'h0000_0000);
    check("wr_instr", Instr, 32'hFFFF_FFFC ^ KEY);
    InstrTake = 1'b1;
    tick();
    InstrTake = 1'b0;
    wait_valid(20, "wr2_valid_to");
    check("wr2_pc",  PC, 32'h0000_0000);
    check("wr2_npc", NPC, 32'h0000_0004);

    // Empty queue when data returns with IF taking
    rst = 1'b1;
    tick(); rst = 1'b0; InstrTake = 1'b1;
    tick(); tick();
    @(negedge clk); #1;
`ifdef PREFETCH_BYPASS_EN
    check("byp_valid", 32'(InstrValid), 32'd1);
    check("byp_pc",    PC, 32'h0000_3000);
    check("byp_npc",   NPC, 32'h0000_3004);
    check("byp_instr", Instr, 32'h0000_3000 ^ KEY);
    tick();
    check("byp_consumed", 32'(InstrValid), 32'd0);
`else
    check("nobyp_valid", 32'(InstrValid), 32'd0);
    check("nobyp_instr", Instr, 32'h0);
    tick();
    check("nobyp_late_valid", 32'(InstrValid), 32'd1);
    check("nobyp_late_pc",    PC, 32'h0000_3000);
`endif
    check("end_req",  32'(MemReq), 32'd1);
    check("end_addr", MemAddr, 32'h0000_3004);
    InstrTake = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
